// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with an integrated issue scoreboard.
//
// Storage is swept to zero by an INIT phase after reset instead of a
// parallel reset, so the array maps onto distributed RAM. Each register
// also has a busy bit. An issue sets the bit, and a write-back clears it.
// Register 0 is hard-wired to zero and is never busy.
//
// Parameters
//   XLEN   - data width in bits
//   NREG   - register count (2..64)
//   NRD    - read-port count (1..4)
//   BYPASS - 1: a same-cycle write-back is forwarded to the read ports
//
// Ports
//   clk       - clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   rs_addr   - packed read addresses, port k at [k*AW +: AW]
//   rs_data   - packed combinational read data, port k at [k*XLEN +: XLEN]
//   rs_busy   - per-port flag: addressed register has an outstanding producer
//   we/rd/wd  - write-back strobe, destination, data
//   iss_valid - issue strobe, marks iss_rd as pending
//   iss_rd    - destination of the issued instruction
//   ready     - high once the INIT sweep has completed
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*$clog2(NREG)-1:0] rs_addr,
    output logic [NRD*XLEN-1:0]     rs_data,
    output logic [NRD-1:0]          rs_busy,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [XLEN-1:0]         wd,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                    ready
);
    localparam int AW    = $clog2(NREG);
    localparam int NADDR = 1 << AW;
    // One bit per encodable address. A bit is set when that address names an
    // implemented register. This covers NREG values that are not a power of two.
    localparam logic [NADDR-1:0] ADDR_OK = {NADDR{1'b1}} >> (NADDR - NREG);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREG];

    logic              run;
    logic              wb_ok;
    logic              iss_ok;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [AW-1:0]     ra;

    assign run    = (state_q == ST_RUN);
    assign ready  = run;
    assign wb_ok  = run && we && (rd != '0) && ADDR_OK[rd];
    assign iss_ok = run && iss_valid && (iss_rd != '0) && ADDR_OK[iss_rd];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = wd;
        case (state_q)
            ST_INIT: begin
                // Clear one register per edge, so the sweep takes NREG edges.
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = '0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wb_ok) begin
                    wr_en      = 1'b1;
                    busy_d[rd] = 1'b0;
                end
                // The set comes after the clear, so an issue to the same
                // register as the write-back leaves its busy bit set.
                if (iss_ok) begin
                    busy_d[iss_rd] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // The storage array has no reset. Its contents are only meaningful once
    // the INIT sweep has cleared every register.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rs_addr[k*AW +: AW];
            if (run && (ra != '0) && ADDR_OK[ra]) begin
                if ((BYPASS != 0) && wb_ok && (rd == ra)) begin
                    rs_data[k*XLEN +: XLEN] = wd;
                end else begin
                    rs_data[k*XLEN +: XLEN] = mem_q[ra];
                    rs_busy[k]              = busy_q[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD*XLEN-1:0] data1, data0;
    logic [NRD-1:0]  busy1, busy0;
    logic            ready1, ready0;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(data1), .rs_busy(busy1),
        .we(we), .rd(rd), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .ready(ready1)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(data0), .rs_busy(busy0),
        .we(we), .rd(rd), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .ready(ready0)
    );

    // Behavioural model: architectural registers, busy flags, and a count of
    // reset-released edges that decides when the file becomes ready.
    logic [XLEN-1:0] m_mem [NREG];
    bit              m_busy [NREG];
    bit              m_run   = 1'b0;
    bit              m_valid = 1'b0;
    int              m_cnt   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_cnt   = 0;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NREG) m_run = 1'b1;
        end else begin
            if (we && rd != 0) begin
                m_mem[rd]  = wd;
                m_busy[rd] = 1'b0;
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return '0;
        if (byp && we && rd == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (!m_run || a == 0) return 1'b0;
        if (byp && we && rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Compare both DUTs against the model on every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready_byp", 32'(ready1), 32'(m_run));
            chk("ready_nob", 32'(ready0), 32'(m_run));
            for (int k = 0; k < NRD; k++) begin
                logic [AW-1:0] a;
                a = rs_addr[k*AW +: AW];
                chk("data_byp", data1[k*XLEN +: XLEN], exp_data(a, 1'b1));
                chk("busy_byp", 32'(busy1[k]), 32'(exp_busy(a, 1'b1)));
                chk("data_nob", data0[k*XLEN +: XLEN], exp_data(a, 1'b0));
                chk("busy_nob", 32'(busy0[k]), 32'(exp_busy(a, 1'b0)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input bit w, input logic [AW-1:0] r, input logic [XLEN-1:0] d,
                         input bit iv, input logic [AW-1:0] ir,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        we        = w;
        rd        = r;
        wd        = d;
        iss_valid = iv;
        iss_rd    = ir;
        rs_addr   = {a1, a0};
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        setin(0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();

        // Init sweep: writes and issues during INIT must be ignored.
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && !ready1; i++) begin
            setin(1, AW'($urandom_range(1, 31)), $urandom, 1, AW'($urandom_range(1, 31)),
                  AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            cyc();
            n++;
        end
        chk("init_len", 32'(n), 32'd32);

        for (int i = 0; i < NREG; i++) begin
            setin(0, 0, 0, 0, 0, AW'(i), AW'(31 - i));
            @(negedge clk);
            chk("sweep_p0", data1[31:0], 32'h0);
            chk("sweep_p1", data1[63:32], 32'h0);
            cyc();
        end

        // Write with bypass.
        setin(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        @(negedge clk);
        chk("bypass_on", data1[31:0], 32'hDEADBEEF);
        chk("bypass_off", data0[31:0], 32'h0);
        cyc();
        setin(0, 0, 0, 0, 0, 5, 0);
        @(negedge clk);
        chk("after_wr_nob", data0[31:0], 32'hDEADBEEF);
        cyc();

        // Scoreboard set then clear.
        setin(0, 0, 0, 1, 7, 7, 0);
        cyc();
        setin(0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("busy7_byp", 32'(busy1[0]), 32'd1);
        chk("busy7_nob", 32'(busy0[0]), 32'd1);
        cyc();
        setin(1, 7, 32'h12, 0, 0, 7, 0);
        @(negedge clk);
        chk("wb7_data_byp", data1[31:0], 32'h12);
        chk("wb7_busy_byp", 32'(busy1[0]), 32'd0);
        chk("wb7_busy_nob", 32'(busy0[0]), 32'd1);
        cyc();
        setin(0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("r7_data", data0[31:0], 32'h12);
        chk("r7_busy", 32'(busy0[0]), 32'd0);
        cyc();

        // Collision: set wins, data still written.
        setin(1, 9, 32'h55, 1, 9, 0, 0);
        cyc();
        setin(0, 0, 0, 0, 0, 9, 9);
        @(negedge clk);
        chk("coll_data", data1[63:32], 32'h55);
        chk("coll_busy", 32'(busy1[1]), 32'd1);
        cyc();

        // Register 0 protection.
        setin(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        @(negedge clk);
        chk("x0_wcycle", data1[31:0], 32'h0);
        cyc();
        setin(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("x0_data", data1[31:0], 32'h0);
        chk("x0_busy", 32'(busy1), 32'd0);
        cyc();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] r;
            r = AW'($urandom_range(0, 31));
            rst_n = ($urandom_range(0, 299) != 0);
            setin(bit'($urandom_range(0, 1)), r, $urandom, bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? r : AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 0) ? r : AW'($urandom_range(0, 31)),
                  AW'($urandom_range(0, 31)));
            cyc();
        end

        // Mid-operation reset.
        rst_n = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !ready1; i++) cyc();
        chk("ready_before_mid", 32'(ready1), 32'd1);
        setin(0, 0, 0, 1, 3, 0, 0);
        cyc();
        setin(0, 0, 0, 1, 4, 0, 0);
        cyc();
        setin(0, 0, 0, 0, 0, 3, 4);
        @(negedge clk);
        chk("busy34", 32'(busy1), 32'd3);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", 32'(ready1), 32'd0);
        chk("mid_busy", 32'(busy1), 32'd0);
        chk("mid_data", data1[31:0], 32'h0);
        n = 0;
        for (int i = 0; i < 100 && !ready1; i++) begin
            cyc();
            n++;
        end
        chk("mid_init_len", 32'(n), 32'd32);
        setin(0, 0, 0, 0, 0, 3, 4);
        @(negedge clk);
        chk("post_busy", 32'(busy1), 32'd0);
        chk("post_data", data1[63:32], 32'h0);
        cyc();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
